// File: rtl/cp0_reg.sv
// Coprocessor-0 register file for the five-stage MIPS core.
// It receives the CP0 write from write-back and holds the Count/Compare timer.
// It samples the hardware interrupt lines into Cause, records precise
// exceptions and clears EXL on ERET.
// Reads are combinational, and a same-cycle write is bypassed onto rdata.
module cp0_reg #(
    parameter logic [31:0] PRID_VAL   = 32'h004C0102,
    parameter logic [31:0] CONFIG_VAL = 32'h00008000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype,
    input  logic [31:0] current_inst_addr,
    input  logic        is_in_delayslot,
    output logic [31:0] rdata,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);

    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_STATUS  = 5'd12;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] ADDR_EPC     = 5'd14;
    localparam logic [4:0] ADDR_PRID    = 5'd15;
    localparam logic [4:0] ADDR_CONFIG  = 5'd16;

    localparam logic [31:0] STATUS_RST = 32'h10000000;

    // Cause bits software may write: IV, WP, IP[1:0]
    localparam logic [31:0] CAUSE_WMASK = 32'h00C00300;

    logic [31:0] count_q,   count_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] status_q,  status_d;
    logic [31:0] cause_q,   cause_d;
    logic [31:0] epc_q,     epc_d;
    logic        timer_q,   timer_d;

    logic        exc_valid;
    logic [4:0]  exc_code;

    // Decode the exception type into an ExcCode; unknown codes are ignored
    always_comb begin
        exc_valid = 1'b0;
        exc_code  = 5'h00;
        case (excepttype)
            32'h0000_0001: begin exc_valid = 1'b1; exc_code = 5'h00; end
            32'h0000_0008: begin exc_valid = 1'b1; exc_code = 5'h08; end
            32'h0000_000a: begin exc_valid = 1'b1; exc_code = 5'h0a; end
            32'h0000_000c: begin exc_valid = 1'b1; exc_code = 5'h0c; end
            32'h0000_000d: begin exc_valid = 1'b1; exc_code = 5'h0d; end
            default:       begin exc_valid = 1'b0; exc_code = 5'h00; end
        endcase
    end

    // Next state: free-running count and interrupt sampling, then the software write,
    // then exception/ERET layered on top so they win for EPC/EXL/BD/ExcCode
    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        status_d  = status_q;
        cause_d   = cause_q;
        epc_d     = epc_q;
        timer_d   = timer_q;

        cause_d[15:10] = int_i;

        if ((compare_q != 32'd0) && (count_q == compare_q)) begin
            timer_d = 1'b1;
        end

        if (we) begin
            case (waddr)
                ADDR_COUNT:   count_d = wdata;
                ADDR_COMPARE: begin
                    compare_d = wdata;
                    timer_d   = 1'b0;
                end
                ADDR_STATUS:  status_d = wdata;
                ADDR_CAUSE:   cause_d = (cause_d & ~CAUSE_WMASK) | (wdata & CAUSE_WMASK);
                ADDR_EPC:     epc_d = wdata;
                default:      ;
            endcase
        end

        if (exc_valid) begin
            // Nested exceptions keep the original return address and BD
            if (!status_q[1]) begin
                epc_d       = is_in_delayslot ? (current_inst_addr - 32'd4) : current_inst_addr;
                cause_d[31] = is_in_delayslot;
            end
            status_d[1]   = 1'b1;
            cause_d[6:2]  = exc_code;
        end else if (excepttype == 32'h0000_000e) begin
            status_d[1] = 1'b0;
        end
    end

    // Register update with synchronous reset overriding writes and exceptions
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            status_q  <= STATUS_RST;
            cause_q   <= 32'd0;
            epc_q     <= 32'd0;
            timer_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            status_q  <= status_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
            timer_q   <= timer_d;
        end
    end

    // Combinational read with same-cycle write bypass; exceptions are not bypassed
    always_comb begin
        rdata = 32'd0;
        case (raddr)
            ADDR_COUNT:   rdata = count_q;
            ADDR_COMPARE: rdata = compare_q;
            ADDR_STATUS:  rdata = status_q;
            ADDR_CAUSE:   rdata = cause_q;
            ADDR_EPC:     rdata = epc_q;
            ADDR_PRID:    rdata = PRID_VAL;
            ADDR_CONFIG:  rdata = CONFIG_VAL;
            default:      rdata = 32'd0;
        endcase
        if (we && (waddr == raddr)) begin
            case (raddr)
                ADDR_COUNT, ADDR_COMPARE, ADDR_STATUS, ADDR_EPC: rdata = wdata;
                ADDR_CAUSE: rdata = (cause_q & ~CAUSE_WMASK) | (wdata & CAUSE_WMASK);
                default:    ;
            endcase
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign status_o    = status_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign config_o    = CONFIG_VAL;
    assign prid_o      = PRID_VAL;
    assign timer_int_o = timer_q;

endmodule

// File: tb/tb_cp0_reg.sv
// Directed testbench for cp0_reg.
// Inputs change and outputs are sampled on the falling edge.
module tb_cp0_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [5:0]  int_i;
    logic [31:0] excepttype;
    logic [31:0] current_inst_addr;
    logic        is_in_delayslot;
    logic [31:0] rdata;
    logic [31:0] count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
    logic        timer_int_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cp0_reg dut (
        .clk               (clk),
        .rst               (rst),
        .we                (we),
        .waddr             (waddr),
        .wdata             (wdata),
        .raddr             (raddr),
        .int_i             (int_i),
        .excepttype        (excepttype),
        .current_inst_addr (current_inst_addr),
        .is_in_delayslot   (is_in_delayslot),
        .rdata             (rdata),
        .count_o           (count_o),
        .compare_o         (compare_o),
        .status_o          (status_o),
        .cause_o           (cause_o),
        .epc_o             (epc_o),
        .config_o          (config_o),
        .prid_o            (prid_o),
        .timer_int_o       (timer_int_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0; int_i = '0;
        excepttype = '0; current_inst_addr = '0; is_in_delayslot = 1'b0;

        // reset
        step();
        check("rst_status", status_o, 32'h10000000);
        check("rst_cause", cause_o, 32'h0);
        check("rst_timer", {31'd0, timer_int_o}, 32'h0);
        check("prid", prid_o, 32'h004C0102);
        check("config", config_o, 32'h00008000);
        step();
        check("rst_count", count_o, 32'h0);
        check("rst_epc", epc_o, 32'h0);
        rst = 1'b0;
        check("count0", count_o, 32'd0);
        step();
        check("count1", count_o, 32'd1);
        step();
        check("count2", count_o, 32'd2);

        // timer: Compare=20 with bypass, then Count=15
        we = 1'b1; waddr = 5'd11; wdata = 32'd20; raddr = 5'd11;
        #1 check("byp_compare", rdata, 32'd20);
        step();
        check("compare20", compare_o, 32'd20);
        waddr = 5'd9; wdata = 32'd15;
        step();
        we = 1'b0;
        check("count_written", count_o, 32'd15);
        check("timer_low_15", {31'd0, timer_int_o}, 32'h0);
        repeat (5) step();
        check("count20", count_o, 32'd20);
        check("timer_low_20", {31'd0, timer_int_o}, 32'h0);
        step();
        check("count21", count_o, 32'd21);
        check("timer_rise", {31'd0, timer_int_o}, 32'h1);
        repeat (3) step();
        check("timer_sticky", {31'd0, timer_int_o}, 32'h1);
        we = 1'b1; waddr = 5'd11; wdata = 32'd100;
        step();
        we = 1'b0;
        check("timer_clear", {31'd0, timer_int_o}, 32'h0);
        check("compare100", compare_o, 32'd100);

        // syscall in delay slot, EXL=0
        excepttype = 32'h8; current_inst_addr = 32'hbfc00104; is_in_delayslot = 1'b1;
        step();
        check("sys_epc", epc_o, 32'hbfc00100);
        check("sys_bd", {31'd0, cause_o[31]}, 32'h1);
        check("sys_code", {27'd0, cause_o[6:2]}, 32'h08);
        check("sys_status", status_o, 32'h10000002);

        // nested overflow, EXL=1
        excepttype = 32'hc; current_inst_addr = 32'h12345678; is_in_delayslot = 1'b0;
        step();
        check("ovf_epc", epc_o, 32'hbfc00100);
        check("ovf_bd", {31'd0, cause_o[31]}, 32'h1);
        check("ovf_code", {27'd0, cause_o[6:2]}, 32'h0c);

        // ERET
        excepttype = 32'he;
        step();
        excepttype = 32'h0;
        check("eret_status", status_o, 32'h10000000);

        // Cause write masking and bypass (cause = 0x80000030 here)
        check("cause_pre", cause_o, 32'h80000030);
        we = 1'b1; waddr = 5'd13; wdata = 32'hffffffff; raddr = 5'd13;
        #1 check("byp_cause", rdata, 32'h80C00330);
        step();
        we = 1'b0;
        check("cause_masked", cause_o, 32'h80C00330);
        check("cause_code_kept", {27'd0, cause_o[6:2]}, 32'h0c);

        // interrupt sampling
        int_i = 6'b100001;
        #1 check("int_not_yet", {26'd0, cause_o[15:10]}, 32'h0);
        step();
        check("int_sampled", {26'd0, cause_o[15:10]}, 32'h21);
        int_i = 6'b000000;

        // read-only and unmapped addresses
        we = 1'b1; waddr = 5'd15; wdata = 32'hdeadbeef; raddr = 5'd15;
        #1 check("prid_ro_byp", rdata, 32'h004C0102);
        step();
        we = 1'b0;
        check("prid_ro", prid_o, 32'h004C0102);
        raddr = 5'd5;
        #1 check("unmapped_rd", rdata, 32'h0);

        // Count wrap
        we = 1'b1; waddr = 5'd9; wdata = 32'hffffffff;
        step();
        we = 1'b0;
        check("count_max", count_o, 32'hffffffff);
        step();
        check("count_wrap", count_o, 32'h0);

        // reset overrides a same-edge write
        rst = 1'b1; we = 1'b1; waddr = 5'd12; wdata = 32'h0000ffff;
        step();
        rst = 1'b0; we = 1'b0;
        check("rst_over_wr", status_o, 32'h10000000);
        check("rst_count2", count_o, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
